// File: rtl/byte_arb_pkg.sv
// Shared types and constants for the round-robin byte stream arbiter.
package byte_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [7:0] HDR_MARK = 8'hA0;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first request searching upward from ptr+1.
module rr_pick
  import byte_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int PW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] pick,
  output logic [PW-1:0]   pick_idx
);

  int   idx;
  logic found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N_CH; off++) begin
      idx = (int'(ptr) + off) % N_CH;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/byte_stream_arbiter.sv
// Round-robin arbiter merging N_CH valid/ready byte streams with bounded bursts.
// Optional per-grant header byte (8'hA0 | channel) enabled by BYTE_ARB_HDR_EN.
module byte_stream_arbiter
  import byte_arb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int BURST = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [8*N_CH-1:0] in_data_i,
  input  logic [N_CH-1:0]   in_valid_i,
  output logic [N_CH-1:0]   in_ready_o,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_CH-1:0]   grant_o,
  output logic              busy_o
);

  localparam int PW = clog2(N_CH);
  localparam int CW = clog2(BURST + 1);

  state_t          state_q, state_d;
  logic [N_CH-1:0] grant_q, pick;
  logic [PW-1:0]   gidx_q, ptr_q, pick_idx;
  logic [CW-1:0]   cnt_q;
  logic            g_valid, xfer, last_beat;

  rr_pick #(.N_CH(N_CH), .PW(PW)) u_pick (
    .req      (in_valid_i),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign g_valid   = in_valid_i[gidx_q];
  assign xfer      = out_valid_o & out_ready_i;
  assign last_beat = (cnt_q == CW'(BURST - 1));

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|in_valid_i) begin
`ifdef BYTE_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef BYTE_ARB_HDR_EN
      ST_HDR:  if (xfer) state_d = ST_DATA;
`endif
      ST_DATA: if (!g_valid || (xfer && last_beat)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PW'(N_CH - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|in_valid_i) begin
            grant_q <= pick;
            gidx_q  <= pick_idx;
            cnt_q   <= '0;
          end
        end
        ST_DATA: begin
          if (state_d == ST_IDLE) begin
            grant_q <= '0;
            ptr_q   <= gidx_q;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  // Handshakes are masked while reset is asserted so a byte seen in that cycle is never consumed.
  always_comb begin
    out_data_o  = '0;
    out_valid_o = 1'b0;
    in_ready_o  = '0;
    case (state_q)
`ifdef BYTE_ARB_HDR_EN
      ST_HDR: begin
        out_data_o  = HDR_MARK | {{(8-PW){1'b0}}, gidx_q};
        out_valid_o = rstn_i;
      end
`endif
      ST_DATA: begin
        out_data_o         = in_data_i[int'(gidx_q)*8 +: 8];
        out_valid_o        = g_valid & rstn_i;
        in_ready_o[gidx_q] = out_ready_i & rstn_i;
      end
      default: ;
    endcase
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule
